vx_count_expander: RTL and testbench

//  Inverse of a population counter: accepts a lane count and expands it into
//  a stream of thermometer lane masks, LANES bits per beat, LSB-first.
//  The popcounts of all emitted masks sum to the accepted count.

---
 rtl/vx_count_expander.sv | 85 ++++++++
 tb/tb_vx_count_expander.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_count_expander.sv
// Expands an accepted lane count into a stream of LSB-first thermometer masks,
// LANES bits per beat, whose popcounts sum to the (saturated) count.
module vx_count_expander #(
    parameter int N      = 10,
    parameter int LANES  = 4,
    parameter int N_BITS = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [N_BITS-1:0] in_count,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LANES-1:0]  out_mask,
    output logic              out_last,
    input  logic              out_ready
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [N_BITS-1:0] remaining;
    logic [N_BITS-1:0] sat_count;
    logic [N_BITS-1:0] next_remaining;
    logic              accept;
    logic              consume;

    function automatic logic [LANES-1:0] mask_of(input logic [N_BITS-1:0] r);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i < int'(r));
        end
        return m;
    endfunction

    function automatic logic last_of(input logic [N_BITS-1:0] r);
        return int'(r) <= LANES;
    endfunction

    assign in_ready = (state == IDLE) || (out_valid && out_last && out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    assign sat_count = (int'(in_count) > N) ? N_BITS'(N) : in_count;

    // Only used when more than LANES lanes remain, so it cannot underflow.
    assign next_remaining = N_BITS'(int'(remaining) - LANES);

    // A new accept always wins over the old request, which can only be on its
    // consumed last beat when in_ready is high in BUSY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            remaining <= '0;
            out_valid <= 1'b0;
            out_mask  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= BUSY;
            remaining <= sat_count;
            out_valid <= 1'b1;
            out_mask  <= mask_of(sat_count);
            out_last  <= last_of(sat_count);
        end else if (consume) begin
            if (out_last) begin
                state     <= IDLE;
                remaining <= '0;
                out_valid <= 1'b0;
                out_mask  <= '0;
                out_last  <= 1'b0;
            end else begin
                state     <= BUSY;
                remaining <= next_remaining;
                out_valid <= 1'b1;
                out_mask  <= mask_of(next_remaining);
                out_last  <= last_of(next_remaining);
            end
        end
    end

endmodule

// File: tb/tb_vx_count_expander.sv
// Directed self-checking bench for vx_count_expander with N=10, LANES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vx_count_expander;

    localparam int N      = 10;
    localparam int LANES  = 4;
    localparam int N_BITS = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic [N_BITS-1:0] in_count;
    logic              in_ready;
    logic              out_valid;
    logic [LANES-1:0]  out_mask;
    logic              out_last;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    vx_count_expander #(.N(N), .LANES(LANES), .N_BITS(N_BITS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_count  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_mask !== 4'b0000 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset valid=%b mask=%b last=%b ready=%b expected 0 0000 0 1",
                     out_valid, out_mask, out_last, in_ready);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_count(input string name, input logic [N_BITS-1:0] count, input int sat);
        logic [3:0] exp_mask [3];
        int sum;
        exp_mask = '{4'b1111, 4'b1111, 4'b0011};
        in_valid = 1'b1; in_count = count; out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b expected 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_mask !== exp_mask[i] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL %s_beat%0d valid=%b mask=%b last=%b expected 1 %b %b",
                         name, i, out_valid, out_mask, out_last, exp_mask[i], (i == 2));
            end
            sum += $countones(out_mask);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle valid=%b ready=%b expected 0 1", name, out_valid, in_ready);
        end
        checks++;
        if (sum != sat) begin
            errors++;
            $display("FAIL %s_popsum got %0d expected %0d", name, sum, sat);
        end
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_count = 0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b0000 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL zero_beat valid=%b mask=%b last=%b expected 1 0000 1",
                     out_valid, out_mask, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int sum;
        in_valid = 1'b1; in_count = 4; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b1111 || out_last !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first valid=%b mask=%b last=%b ready=%b expected 1 1111 1 1",
                     out_valid, out_mask, out_last, in_ready);
        end
        sum = $countones(out_mask);
        in_count = 5;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b1111 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second valid=%b mask=%b last=%b expected 1 1111 0",
                     out_valid, out_mask, out_last);
        end
        sum += $countones(out_mask);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b0001 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_third valid=%b mask=%b last=%b expected 1 0001 1",
                     out_valid, out_mask, out_last);
        end
        sum += $countones(out_mask);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum != 9) begin
            errors++;
            $display("FAIL b2b_end valid=%b popsum=%0d expected 0 9", out_valid, sum);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_count = 7; out_ready = 1'b0;
        @(negedge clk);
        // Offer a different count while busy; it must be ignored.
        in_count = 2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_mask !== 4'b1111 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d valid=%b mask=%b last=%b ready=%b expected 1 1111 0 0",
                         i, out_valid, out_mask, out_last, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_mask !== 4'b1111 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b mask=%b expected 1 1111", out_valid, out_mask);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b0111 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_last valid=%b mask=%b last=%b expected 1 0111 1",
                     out_valid, out_mask, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_request();
        in_valid = 1'b1; in_count = 10; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b1111 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_beat2 valid=%b mask=%b last=%b expected 1 1111 0",
                     out_valid, out_mask, out_last);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_mask !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async valid=%b mask=%b expected 0 0000", out_valid, out_mask);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet%0d valid=%b expected 0", i, out_valid);
            end
        end
        in_valid = 1'b1; in_count = 3;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 4'b0111 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_new valid=%b mask=%b last=%b expected 1 0111 1",
                     out_valid, out_mask, out_last);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_new_idle valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_count("full", 4'd10, 10);
        test_zero();
        test_back_to_back();
        test_stall();
        test_count("saturate", 4'd15, 10);
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
